washer_program_controller: RTL and testbench
============================================

# washer_program_controller

Parametrised, multi-program successor to the single-cycle washing machine controller. It accepts a coin and runs a selectable wash program through the phases FILL, WASH, RINSE and SPIN, with phase durations set in minutes by parameter. The controller has a pause that freezes every phase, an abort, a selectable reference clock, and live phase/remaining-time status. It sits between the front-panel inputs and the motor/valve drivers, and is one instance per machine.

## Interface
- BASE_HZ, 1_000_000: clock frequency when clk_freq = 2'b00.
- SEC_PER_MIN, 60: seconds per minute. The bench may reduce it for short runs.
- FILL_MIN, 2: FILL duration in minutes.
- WASH_MIN, 5: WASH duration in minutes.
- QUICK_WASH_MIN, 2: WASH duration in the quick program.
- RINSE_MIN, 2: RINSE duration in minutes.
- SPIN_MIN, 1: SPIN duration in minutes.
- MIN_W, 6: width of minutes_left.

Ports:
- clk  in  1: single clock.
- rst_n  in  1: reset, synchronous, active-low.
- clk_freq  in  2: selects the clock frequency, BASE_HZ << clk_freq (1/2/4/8 MHz at default).
- coin_in  in  1: start request.
- prog  in  2: program select. 00 = normal, 01 = double wash, 10 = quick, 11 = rinse+spin.
- timer_pause  in  1: while high, freezes the active phase timer.
- abort  in  1: cancels the run.
- phase  out  3: current phase code (IDLE = 0, FILL = 1, WASH = 2, RINSE = 3, SPIN = 4).
- busy  out  1: high whenever phase != IDLE.
- minutes_left  out  MIN_W: whole minutes remaining in the current phase, rounded up.
- wash_done  out  1: completion flag.

## Operation
- IDLE: coin_in high on a rising edge latches prog and clk_freq and enters FILL at that edge. Both latched values hold until the next return to IDLE. Later changes to prog or clk_freq have no effect on the run.
- Phase sequence by program:
  - normal: FILL → WASH → RINSE → SPIN → IDLE.
  - double: FILL → WASH → RINSE → WASH → RINSE → SPIN → IDLE. There is no second fill. A 1-bit pass counter selects between the two passes.
  - quick: as normal, except WASH lasts QUICK_WASH_MIN.
  - rinse+spin: FILL → RINSE → SPIN → IDLE.
- Timer structure: prescaler counts (BASE_HZ << clk_freq_latched) cycles per second, a second counter runs 0..SEC_PER_MIN-1, and a minute counter loads the phase duration on phase entry and decrements once per minute. The phase exits on the edge where the minute counter reaches 0.
- timer_pause: holds the prescaler, second counter and minute counter in every non-IDLE phase. No state change occurs while paused. Pause is ignored in IDLE.
- abort: when high in a non-IDLE phase, the next edge goes to IDLE, clears all counters, and leaves wash_done = 0. abort has priority over pause and over a coinciding phase expiry.
- wash_done: set on the edge that enters IDLE from SPIN. Held high in IDLE. Cleared on the edge that accepts the next coin.
- coin_in is ignored while busy.
- Reset: phase = IDLE, busy = 0, minutes_left = 0, wash_done = 0, all counters = 0, pass = 0. Reset mid-run abandons the run.

## Timing
- Coin is accepted on edge N, so phase = FILL after edge N and busy rises in the same cycle.
- Each phase with duration D lasts exactly D × SEC_PER_MIN × (BASE_HZ << f) cycles, plus the number of cycles timer_pause was high.
- The transition edge loads the next phase's counter, so there is no idle gap between phases.
- minutes_left equals D on phase entry and decrements at each minute boundary. It reads 0 in IDLE.
- Registered outputs only. Zero combinational paths from inputs to outputs.
- Counter widths are derived with $clog2 of the maximum value, i.e. BASE_HZ << 3.

## Structure
- Package washer_pkg: phase enum codes, program codes, and a function mapping (prog, phase, pass) to minute duration.
- Sub-module washer_timer: prescaler, seconds counter and minute down-counter. Inputs are load, load_val, freeze and clr; outputs are expired and minutes_left.
- Top level: phase FSM, pass counter, input latches, and the wash_done register.

## Test plan
- Normal program, clk_freq = 00, BASE_HZ = 1e6 → FILL/WASH/RINSE/SPIN last exactly 2/5/2/1 min. wash_done rises on the edge entering IDLE and stays high until the next coin.
- Double program → phase durations 2, 5, 2, 5, 2, 1 min (17 min total), with no second FILL.
- Quick program with clk_freq = 2'b11 (8 MHz clock) → WASH lasts 2 min of 8 MHz cycles. Changing clk_freq to 00 mid-run does not change any duration.
- timer_pause high for 30 s in the middle of WASH → WASH lasts 5.5 min wall time. minutes_left is frozen while paused.
- abort asserted in RINSE, and separately on the exact expiry edge of SPIN → next edge IDLE with wash_done = 0. A coin during busy is ignored.
- rst_n low for one edge mid-WASH → all outputs take reset values. A fresh coin then runs a full normal program correctly.

Source files
------------

// File: rtl/washer_pkg.sv
// Shared definitions for the washer program controller.
// Holds the phase and program encodings and the lookup that turns a
// (program, phase, pass) triple into the number of minutes the phase runs.
package washer_pkg;

  // Phase codes are exposed on the phase output, so the values are fixed.
  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_FILL  = 3'd1,
    PH_WASH  = 3'd2,
    PH_RINSE = 3'd3,
    PH_SPIN  = 3'd4
  } phase_e;

  typedef enum logic [1:0] {
    PROG_NORMAL     = 2'b00,
    PROG_DOUBLE     = 2'b01,
    PROG_QUICK      = 2'b10,
    PROG_RINSE_SPIN = 2'b11
  } prog_e;

  // Minute duration of a phase. Returning 0 marks a combination that no
  // program ever reaches: IDLE, a WASH in rinse+spin, a second FILL, or a
  // second pass in a program that only runs one pass.
  function automatic int unsigned phase_minutes(
    input prog_e       prog,
    input phase_e      ph,
    input logic        pass,
    input int unsigned fill_min,
    input int unsigned wash_min,
    input int unsigned quick_wash_min,
    input int unsigned rinse_min,
    input int unsigned spin_min
  );
    int unsigned m;
    m = 0;
    case (ph)
      PH_FILL:  m = pass ? 0 : fill_min;
      PH_WASH: begin
        if (prog == PROG_RINSE_SPIN)  m = 0;
        else if (prog == PROG_QUICK)  m = quick_wash_min;
        else                          m = wash_min;
      end
      PH_RINSE: m = rinse_min;
      PH_SPIN:  m = spin_min;
      default:  m = 0;
    endcase
    if (pass && (prog != PROG_DOUBLE)) m = 0;
    return m;
  endfunction

endpackage

// File: rtl/washer_program_controller_timer.sv
// Phase timer for the washer controller.
// A prescaler divides the clock down to one tick per second, a second
// counter groups ticks into minutes, and a minute down-counter holds the
// time left in the current phase.
// Ports:
//   clk, rst_n    clock and synchronous active-low reset
//   freq_sel      latched clock select; one second = BASE_HZ << freq_sel cycles
//   load          restart all counters and load load_val minutes
//   load_val      minute count for the phase being entered
//   freeze        hold every counter
//   clr           zero every counter (wins over load and freeze)
//   expired       high in the cycle whose edge ends the last minute
//   minutes_left  registered minute down-counter
module washer_program_controller_timer #(
  parameter int unsigned BASE_HZ     = 1_000_000,
  parameter int unsigned SEC_PER_MIN = 60,
  parameter int unsigned MIN_W       = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       freq_sel,
  input  logic             load,
  input  logic [MIN_W-1:0] load_val,
  input  logic             freeze,
  input  logic             clr,
  output logic             expired,
  output logic [MIN_W-1:0] minutes_left
);

  localparam int unsigned MAX_CYC = BASE_HZ << 3;
  localparam int PRE_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int SEC_W = (SEC_PER_MIN > 1) ? $clog2(SEC_PER_MIN) : 1;
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_PER_MIN - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic [SEC_W-1:0] sec_cnt;
  logic [MIN_W-1:0] min_cnt;
  logic [PRE_W-1:0] pre_last;
  logic             pre_wrap;
  logic             min_tick;

  // Terminal counts. The prescaler limit follows the latched clock select so
  // a second is always one real second regardless of the clock in use.
  always_comb begin
    pre_last = PRE_W'((BASE_HZ << freq_sel) - 32'd1);
    pre_wrap = (pre_cnt == pre_last);
    min_tick = pre_wrap && (sec_cnt == SEC_LAST);
    expired  = !freeze && min_tick && (min_cnt == MIN_W'(1));
  end

  // Counter chain. Counting stops once the minute counter is empty so an
  // unloaded timer sits still.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      pre_cnt <= '0;
      sec_cnt <= '0;
      min_cnt <= '0;
    end else if (load) begin
      pre_cnt <= '0;
      sec_cnt <= '0;
      min_cnt <= load_val;
    end else if (!freeze && (min_cnt != '0)) begin
      if (pre_wrap) begin
        pre_cnt <= '0;
        if (sec_cnt == SEC_LAST) begin
          sec_cnt <= '0;
          min_cnt <= min_cnt - MIN_W'(1);
        end else begin
          sec_cnt <= sec_cnt + SEC_W'(1);
        end
      end else begin
        pre_cnt <= pre_cnt + PRE_W'(1);
      end
    end
  end

  assign minutes_left = min_cnt;

endmodule

// File: rtl/washer_program_controller.sv
// Multi-program washing machine controller.
// Takes a coin, then steps through FILL/WASH/RINSE/SPIN according to the
// selected program, timing each phase in minutes. Supports pause, abort,
// a selectable reference clock and live phase / minutes-left status.
// Ports:
//   clk, rst_n    clock and synchronous active-low reset
//   clk_freq      clock select, BASE_HZ << clk_freq Hz (latched on coin)
//   coin_in       start request, honoured only in IDLE
//   prog          program select (latched on coin)
//   timer_pause   freeze the running phase
//   abort         cancel the running program
//   phase         current phase code
//   busy          high outside IDLE
//   minutes_left  whole minutes left in the current phase, rounded up
//   wash_done     set when a program completes, cleared by the next coin
module washer_program_controller #(
  parameter int unsigned BASE_HZ        = 1_000_000,
  parameter int unsigned SEC_PER_MIN    = 60,
  parameter int unsigned FILL_MIN       = 2,
  parameter int unsigned WASH_MIN       = 5,
  parameter int unsigned QUICK_WASH_MIN = 2,
  parameter int unsigned RINSE_MIN      = 2,
  parameter int unsigned SPIN_MIN       = 1,
  parameter int unsigned MIN_W          = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       clk_freq,
  input  logic             coin_in,
  input  logic [1:0]       prog,
  input  logic             timer_pause,
  input  logic             abort,
  output logic [2:0]       phase,
  output logic             busy,
  output logic [MIN_W-1:0] minutes_left,
  output logic             wash_done
);

  import washer_pkg::*;

  phase_e      state_q, state_d;
  prog_e       prog_q, prog_d;
  logic [1:0]  freq_q, freq_d;
  logic        pass_q, pass_d;
  logic        done_q, done_d;

  logic        t_load, t_clr, t_freeze, t_expired;
  int unsigned load_min;
  logic [MIN_W-1:0] t_minutes;

  washer_program_controller_timer #(
    .BASE_HZ    (BASE_HZ),
    .SEC_PER_MIN(SEC_PER_MIN),
    .MIN_W      (MIN_W)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .freq_sel    (freq_q),
    .load        (t_load),
    .load_val    (MIN_W'(load_min)),
    .freeze      (t_freeze),
    .clr         (t_clr),
    .expired     (t_expired),
    .minutes_left(t_minutes)
  );

  // State register plus the latched program, clock select, pass bit and
  // completion flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PH_IDLE;
      prog_q  <= PROG_NORMAL;
      freq_q  <= 2'b00;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prog_q  <= prog_d;
      freq_q  <= freq_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

  // Next-state and timer control. Priority in a running phase is abort,
  // then pause, then phase expiry. The expiry edge loads the next phase's
  // duration so phases run back to back. The coin edge uses the live prog
  // input because the latch only updates on that same edge.
  always_comb begin
    state_d  = state_q;
    prog_d   = prog_q;
    freq_d   = freq_q;
    pass_d   = pass_q;
    done_d   = done_q;
    t_load   = 1'b0;
    t_clr    = 1'b0;
    t_freeze = 1'b0;
    load_min = 0;

    if (state_q == PH_IDLE) begin
      t_clr = 1'b1;
      if (coin_in) begin
        state_d  = PH_FILL;
        prog_d   = prog_e'(prog);
        freq_d   = clk_freq;
        pass_d   = 1'b0;
        done_d   = 1'b0;
        t_clr    = 1'b0;
        t_load   = 1'b1;
        load_min = phase_minutes(prog_e'(prog), PH_FILL, 1'b0, FILL_MIN,
                                 WASH_MIN, QUICK_WASH_MIN, RINSE_MIN, SPIN_MIN);
      end
    end else if (abort) begin
      state_d = PH_IDLE;
      pass_d  = 1'b0;
      done_d  = 1'b0;
      t_clr   = 1'b1;
    end else if (timer_pause) begin
      t_freeze = 1'b1;
    end else if (t_expired) begin
      t_load = 1'b1;
      case (state_q)
        PH_FILL:  state_d = (prog_q == PROG_RINSE_SPIN) ? PH_RINSE : PH_WASH;
        PH_WASH:  state_d = PH_RINSE;
        PH_RINSE: begin
          if ((prog_q == PROG_DOUBLE) && !pass_q) begin
            state_d = PH_WASH;
            pass_d  = 1'b1;
          end else begin
            state_d = PH_SPIN;
          end
        end
        PH_SPIN: begin
          state_d = PH_IDLE;
          pass_d  = 1'b0;
          done_d  = 1'b1;
        end
        default:  state_d = PH_IDLE;
      endcase
      load_min = phase_minutes(prog_q, state_d, pass_d, FILL_MIN, WASH_MIN,
                               QUICK_WASH_MIN, RINSE_MIN, SPIN_MIN);
    end
  end

  assign phase        = state_q;
  assign busy         = (state_q != PH_IDLE);
  assign minutes_left = t_minutes;
  assign wash_done    = done_q;

endmodule

// File: tb/tb_washer_program_controller.sv
// Self-checking bench for washer_program_controller.
// A segment-list model predicts phase, busy, minutes_left and wash_done on
// every cycle; directed sequences add literal checks on phase lengths and
// specific status values.
module tb_washer_program_controller;

  localparam int BASE_HZ     = 2;
  localparam int SEC_PER_MIN = 4;
  localparam int MIN_W       = 6;

  logic             clk;
  logic             rst_n;
  logic [1:0]       clk_freq;
  logic             coin_in;
  logic [1:0]       prog;
  logic             timer_pause;
  logic             abort;
  logic [2:0]       phase;
  logic             busy;
  logic [MIN_W-1:0] minutes_left;
  logic             wash_done;

  int assertCount = 0;
  int failCount   = 0;
  bit checkEn     = 0;

  washer_program_controller #(
    .BASE_HZ       (BASE_HZ),
    .SEC_PER_MIN   (SEC_PER_MIN),
    .FILL_MIN      (2),
    .WASH_MIN      (5),
    .QUICK_WASH_MIN(2),
    .RINSE_MIN     (2),
    .SPIN_MIN      (1),
    .MIN_W         (MIN_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_freq    (clk_freq),
    .coin_in     (coin_in),
    .prog        (prog),
    .timer_pause (timer_pause),
    .abort       (abort),
    .phase       (phase),
    .busy        (busy),
    .minutes_left(minutes_left),
    .wash_done   (wash_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Model: a run is a list of (phase, minutes) segments; each segment lasts
  // minutes * cycles-per-minute unpaused cycles.
  int mPhase = 0;
  int mRem   = 0;
  int mCpm   = 1;
  int mDone  = 0;
  int segPh[$];
  int segMin[$];

  task automatic nextSeg();
    mPhase = segPh.pop_front();
    mRem   = segMin.pop_front() * mCpm;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      mPhase = 0; mRem = 0; mDone = 0;
      segPh.delete(); segMin.delete();
    end else if (mPhase == 0) begin
      if (coin_in) begin
        mCpm = SEC_PER_MIN * (BASE_HZ << clk_freq);
        case (prog)
          2'd0:    begin segPh = {1, 2, 3, 4};       segMin = {2, 5, 2, 1};       end
          2'd1:    begin segPh = {1, 2, 3, 2, 3, 4}; segMin = {2, 5, 2, 5, 2, 1}; end
          2'd2:    begin segPh = {1, 2, 3, 4};       segMin = {2, 2, 2, 1};       end
          default: begin segPh = {1, 3, 4};          segMin = {2, 2, 1};          end
        endcase
        mDone = 0;
        nextSeg();
      end
    end else if (abort) begin
      mPhase = 0; mRem = 0;
      segPh.delete(); segMin.delete();
    end else if (!timer_pause) begin
      mRem--;
      if (mRem == 0) begin
        if (segPh.size() == 0) begin
          mPhase = 0;
          mDone  = 1;
        end else begin
          nextSeg();
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model phase", int'(phase), mPhase);
      checkOutput("model busy", int'(busy), int'(mPhase != 0));
      checkOutput("model minutes_left", int'(minutes_left),
                  (mPhase == 0) ? 0 : (mRem + mCpm - 1) / mCpm);
      checkOutput("model wash_done", int'(wash_done), mDone);
    end
  end

  task automatic applyStimulus(input logic c, input logic [1:0] p, input logic [1:0] f,
                               input logic tp, input logic ab);
    coin_in     = c;
    prog        = p;
    clk_freq    = f;
    timer_pause = tp;
    abort       = ab;
  endtask

  // Pulse a coin for one edge; returns at the first sample inside FILL.
  task automatic startRun(input logic [1:0] p, input logic [1:0] f);
    applyStimulus(1'b1, p, f, 1'b0, 1'b0);
    @(negedge clk);
    coin_in = 1'b0;
  endtask

  // Count cycles until the phase changes, then check length and new phase.
  task automatic expectPhase(input int expNext, input int expCycles, input string name);
    int n;
    logic [2:0] start;
    n = 0;
    start = phase;
    while (phase == start && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " length"}, n, expCycles);
    checkOutput({name, " next phase"}, int'(phase), expNext);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkEn = 1;
    checkOutput("reset phase", int'(phase), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset minutes_left", int'(minutes_left), 0);
    checkOutput("reset wash_done", int'(wash_done), 0);
    // Coin must not start anything while rst_n is low.
    @(negedge clk);

    // Normal program, 1 minute = 8 cycles at clk_freq 00.
    $display("[TB] normal program");
    startRun(2'b00, 2'b00);
    checkOutput("normal entry phase", int'(phase), 1);
    checkOutput("normal entry busy", int'(busy), 1);
    checkOutput("normal entry minutes", int'(minutes_left), 2);
    expectPhase(2, 16, "normal fill");
    checkOutput("normal wash minutes", int'(minutes_left), 5);
    expectPhase(3, 40, "normal wash");
    expectPhase(4, 16, "normal rinse");
    expectPhase(0, 8, "normal spin");
    checkOutput("normal done", int'(wash_done), 1);
    repeat (5) @(negedge clk);
    checkOutput("normal done held", int'(wash_done), 1);
    checkOutput("idle minutes", int'(minutes_left), 0);

    // Double program; a coin during WASH is ignored.
    $display("[TB] double program");
    startRun(2'b01, 2'b00);
    checkOutput("double coin clears done", int'(wash_done), 0);
    expectPhase(2, 16, "double fill");
    coin_in = 1'b1;
    @(negedge clk);
    coin_in = 1'b0;
    checkOutput("busy coin ignored phase", int'(phase), 2);
    checkOutput("busy coin ignored minutes", int'(minutes_left), 5);
    expectPhase(3, 39, "double wash1");
    expectPhase(2, 16, "double rinse1");
    expectPhase(3, 40, "double wash2");
    expectPhase(4, 16, "double rinse2");
    expectPhase(0, 8, "double spin");
    checkOutput("double done", int'(wash_done), 1);

    // Quick program at 8x clock; later input changes have no effect.
    $display("[TB] quick program");
    startRun(2'b10, 2'b11);
    applyStimulus(1'b0, 2'b01, 2'b00, 1'b0, 1'b0);
    expectPhase(2, 128, "quick fill");
    expectPhase(3, 128, "quick wash");
    expectPhase(4, 128, "quick rinse");
    expectPhase(0, 64, "quick spin");

    // Rinse+spin program skips WASH.
    $display("[TB] rinse+spin program");
    startRun(2'b11, 2'b00);
    expectPhase(3, 16, "rs fill");
    expectPhase(4, 16, "rs rinse");
    expectPhase(0, 8, "rs spin");

    // Pause for 30 s (4 cycles) in WASH: 44 cycles total.
    $display("[TB] pause and abort at spin expiry");
    startRun(2'b00, 2'b00);
    expectPhase(2, 16, "pause fill");
    repeat (15) @(negedge clk);
    checkOutput("pre-pause minutes", int'(minutes_left), 4);
    timer_pause = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("paused minutes", int'(minutes_left), 4);
    checkOutput("paused phase", int'(phase), 2);
    timer_pause = 1'b0;
    expectPhase(3, 25, "pause wash rest");
    expectPhase(4, 16, "pause rinse");
    repeat (7) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort at expiry phase", int'(phase), 0);
    checkOutput("abort at expiry done", int'(wash_done), 0);
    checkOutput("abort at expiry minutes", int'(minutes_left), 0);

    // Abort in RINSE, with pause also high.
    $display("[TB] abort in rinse");
    startRun(2'b00, 2'b00);
    expectPhase(2, 16, "abort fill");
    expectPhase(3, 40, "abort wash");
    repeat (5) @(negedge clk);
    abort = 1'b1;
    timer_pause = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    timer_pause = 1'b0;
    checkOutput("abort rinse phase", int'(phase), 0);
    checkOutput("abort rinse busy", int'(busy), 0);
    checkOutput("abort rinse done", int'(wash_done), 0);
    repeat (3) @(negedge clk);

    // Reset mid-WASH, then a full normal run.
    $display("[TB] reset mid-run");
    startRun(2'b00, 2'b00);
    expectPhase(2, 16, "reset fill");
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midrun reset phase", int'(phase), 0);
    checkOutput("midrun reset minutes", int'(minutes_left), 0);
    checkOutput("midrun reset done", int'(wash_done), 0);
    startRun(2'b00, 2'b00);
    expectPhase(2, 16, "post-reset fill");
    expectPhase(3, 40, "post-reset wash");
    expectPhase(4, 16, "post-reset rinse");
    expectPhase(0, 8, "post-reset spin");
    checkOutput("post-reset done", int'(wash_done), 1);
    repeat (2) @(negedge clk);

    checkEn = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
